// File: rtl/mult_seq_legv8_pkg.sv
// Shared types and constants for the sequential shift-add multiplier and its ALU.
// Optional build macro used by the top: MULT_SEQ_EARLY_EXIT_EN.
package mult_seq_legv8_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 6;

   localparam logic [CNT_W-1:0] ITER_LAST = 6'd63;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // FS[4:2] picks the operation; FS[1] inverts B and FS[0] inverts A.
   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_OR  = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_XOR = 5'b01100;
   localparam logic [4:0] FS_LSL = 5'b10000;
   localparam logic [4:0] FS_LSR = 5'b10100;

   localparam int STAT_V = 3;
   localparam int STAT_C = 2;
   localparam int STAT_N = 1;
   localparam int STAT_Z = 0;

endpackage

// File: rtl/mult_seq_legv8_alu.sv
// LEGv8-style 64-bit ALU: logic ops, add with carry-in, shifts, and V/C/N/Z status.
module ALU_LEGv8
   import mult_seq_legv8_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [4:0]        fs_i,
   input  logic              c0_i,
   output logic [DATA_W-1:0] f_o,
   output logic [3:0]        status_o
);

   logic [DATA_W-1:0] a_op;
   logic [DATA_W-1:0] b_op;
   logic [DATA_W:0]   sum;
   logic              carry;
   logic              ovfl;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      f_o      = '0;
      carry    = 1'b0;
      ovfl     = 1'b0;
      status_o = '0;

      a_op = fs_i[0] ? ~a_i : a_i;
      b_op = fs_i[1] ? ~b_i : b_i;
      sum  = {1'b0, a_op} + {1'b0, b_op} + {{DATA_W{1'b0}}, c0_i};

      case (fs_i[4:2])
         FS_AND[4:2]: f_o = a_op & b_op;
         FS_OR[4:2]:  f_o = a_op | b_op;
         FS_ADD[4:2]: begin
            f_o   = sum[DATA_W-1:0];
            carry = sum[DATA_W];
            ovfl  = (a_op[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1] != a_op[DATA_W-1]);
         end
         FS_XOR[4:2]: f_o = a_op ^ b_op;
         FS_LSL[4:2]: f_o = a_i << b_i[5:0];
         FS_LSR[4:2]: f_o = a_i >> b_i[5:0];
         default:     f_o = '0;
      endcase

      status_o[STAT_V] = ovfl;
      status_o[STAT_C] = carry;
      status_o[STAT_N] = f_o[DATA_W-1];
      status_o[STAT_Z] = (f_o == '0);
   end

endmodule

// File: rtl/mult_seq_legv8.sv
// Sequential 64x64 unsigned shift-add multiplier (low 64 bits plus overflow flag).
// Define MULT_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_seq_legv8
   import mult_seq_legv8_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product,
   output logic              ovf
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] product_q, product_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] alu_f;
   logic [3:0]        alu_status;
   logic [DATA_W-1:0] mplier_shr;
   logic              last_iter;
   logic              unused_status;

   ALU_LEGv8 u_alu (
      .a_i      (acc_q),
      .b_i      (mcand_q),
      .fs_i     (FS_ADD),
      .c0_i     (1'b0),
      .f_o      (alu_f),
      .status_o (alu_status)
   );

   assign unused_status = ^{alu_status[STAT_V], alu_status[STAT_N], alu_status[STAT_Z]};

   assign mplier_shr = {1'b0, mplier_q[DATA_W-1:1]};

`ifdef MULT_SEQ_EARLY_EXIT_EN
   assign last_iter = (count_q == ITER_LAST) || (mplier_shr == '0);
`else
   assign last_iter = (count_q == ITER_LAST);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      product_d = product_q;
      count_d   = count_q;
      ovf_d     = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d    = '0;
               mcand_d  = A;
               mplier_d = B;
               count_d  = '0;
               ovf_d    = 1'b0;
               state_d  = ADD;
            end
         end
         ADD: begin
            if (mplier_q[0]) begin
               acc_d = alu_f;
               if (alu_status[STAT_C]) ovf_d = 1'b1;
            end
            state_d = SHIFT;
         end
         SHIFT: begin
            mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
            mplier_d = mplier_shr;
            count_d  = count_q + 1'b1;
            // A partial-product bit pushed past bit 63 still has multiplier bits left to meet it.
            if (mcand_q[DATA_W-1] && (mplier_shr != '0)) ovf_d = 1'b1;
            if (last_iter) begin
               // acc is final here, so loading product now makes it valid during the done pulse.
               product_d = acc_q;
               state_d   = DONE;
            end else begin
               state_d = ADD;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign product = product_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_mult_seq_legv8.sv
// Self-checking bench for mult_seq_legv8: directed corner cases plus random pairs against a 128-bit model.
module tb_mult_seq_legv8;

   localparam int BUDGET = 200;
   localparam int N_RAND = 300;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [63:0] A;
   logic [63:0] B;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   mult_seq_legv8 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .product (product),
      .ovf     (ovf)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mul128(input logic [63:0] a, input logic [63:0] b);
      return {64'd0, a} * {64'd0, b};
   endfunction

   // Cycle (counting the accepted start cycle as 0) in which done is expected.
   function automatic int exp_latency(input logic [63:0] b);
      int k = 1;
      for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      return 2 * k + 1;
`else
      return 2 * 64 + 1;
`endif
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One operation; pulse_at > 0 re-asserts start (with junk operands) in that cycle of the run.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input int pulse_at);
      logic [127:0] p;
      int           lat;
      int           cyc;
      bit           seen;
      bit           busy_ok;
      p       = mul128(a, b);
      lat     = exp_latency(b);
      A       = a;
      B       = b;
      start   = 1'b1;
      cyc     = 0;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (!seen && cyc < BUDGET) begin
         tick();
         cyc++;
         start = (cyc == pulse_at);
         A     = rand64();
         B     = rand64();
         if (!busy) busy_ok = 1'b0;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({tag, " done_seen"}, 64'(seen), 64'd1);
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      check({tag, " product"}, product, p[63:0]);
      check({tag, " ovf"}, 64'(ovf), 64'(|p[127:64]));
      check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
      tick();
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      check({tag, " idle_after"}, 64'(busy), 64'd0);
      check({tag, " product_held"}, product, p[63:0]);
      check({tag, " ovf_held"}, 64'(ovf), 64'(|p[127:64]));
   endtask

   initial begin
      int          cyc;
      int          d1;
      int          d2;
      int          lat;
      bit          flag;
      logic [63:0] ra;
      logic [63:0] rb;

      reset_n = 1'b0;
      start   = 1'b0;
      A       = '0;
      B       = '0;
      repeat (3) tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset product", product, 64'd0);
      check("reset ovf", 64'(ovf), 64'd0);
      reset_n = 1'b1;
      repeat (2) tick();
      check("idle no start", 64'(busy), 64'd0);

      run_op("mul_3x5", 64'd3, 64'd5, 0);
      run_op("ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
      run_op("pow32_sq", 64'h1_0000_0000, 64'h1_0000_0000, 0);
      run_op("b_zero", 64'h0000_0000_0000_1234, 64'd0, 0);
      run_op("msb_x3", 64'h8000_0000_0000_0000, 64'd3, 0);
      run_op("start_ignored", 64'h0000_0123_4567_89AB, 64'h0000_0000_0000_F00D, 10);
      run_op("ones_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("a_zero", 64'd0, 64'hDEAD_BEEF_0000_0001, 0);

      // Reset in cycle 20 of a running operation.
      A     = 64'h0000_0000_1234_5678;
      B     = 64'hFFFF_FFFF_FFFF_FFFF;
      start = 1'b1;
      cyc   = 0;
      while (cyc < 20) begin
         tick();
         cyc++;
         start = 1'b0;
      end
      check("midop busy_before_reset", 64'(busy), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midop reset busy", 64'(busy), 64'd0);
      check("midop reset product", product, 64'd0);
      check("midop reset ovf", 64'(ovf), 64'd0);
      flag = 1'b0;
      repeat (2) begin
         tick();
         if (done || busy) flag = 1'b1;
      end
      reset_n = 1'b1;
      repeat (5) begin
         tick();
         if (done || busy) flag = 1'b1;
      end
      check("midop no_done_no_restart", 64'(flag), 64'd0);
      run_op("after_reset", 64'h0000_0000_1234_5678, 64'h0000_0000_0000_0ABC, 0);

      // Back-to-back: start held high through the first done.
      A     = 64'd7;
      B     = 64'd9;
      start = 1'b1;
      lat   = exp_latency(64'd9);
      cyc   = 0;
      d1    = -1;
      d2    = -1;
      while (d2 < 0 && cyc < 2 * BUDGET) begin
         tick();
         cyc++;
         if (done) begin
            if (d1 < 0) begin
               d1 = cyc;
               check("b2b first product", product, 64'd63);
            end else begin
               d2 = cyc;
            end
         end
      end
      start = 1'b0;
      check("b2b first latency", 64'(d1), 64'(lat));
      check("b2b second latency", 64'(d2), 64'(2 * lat + 1));
      check("b2b second product", product, 64'd63);
      check("b2b second ovf", 64'(ovf), 64'd0);
      tick();
      check("b2b idle", 64'(busy), 64'd0);

      for (int i = 0; i < N_RAND; i++) begin
         int w;
         ra = rand64();
         rb = rand64();
         w  = $urandom_range(0, 64);
         if (w < 64) rb = rb & ((64'd1 << w) - 64'd1);
         run_op($sformatf("rand%0d", i), ra, rb, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
